mem_peri_bus: RTL and testbench

//  Data-side bus target of the pipelined MIPS core: word RAM with byte-enable writes plus a peripheral

---
 rtl/mem_peri_pkg.sv | 47 ++++
 rtl/mem_peri_bus_timer.sv | 80 ++++++++
 rtl/mem_peri_bus.sv | 169 ++++++++++++++++
 tb/tb_mem_peri_bus.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_peri_pkg.sv
// Shared constants for the MEM-stage data bus target: address map, timer
// register layout, CTRL bit positions and the byte-enable merge helper.
package mem_peri_pkg;

  // Top address nibble selecting each region
  localparam logic [3:0] RAM_NIBBLE  = 4'h0;
  localparam logic [3:0] PERI_NIBBLE = 4'h4;

  // Timer block layout: one 16-byte slot per channel, word offsets inside it
  localparam int         TIMER_STRIDE = 16;
  localparam logic [1:0] OFF_RELOAD   = 2'd0;
  localparam logic [1:0] OFF_COUNT    = 2'd1;
  localparam logic [1:0] OFF_CTRL     = 2'd2;

  // Fixed registers, as offsets inside the peripheral page
  localparam logic [27:0] OFF_LEDS   = 28'h000_0100;
  localparam logic [27:0] OFF_DIGITS = 28'h000_0104;
  localparam logic [27:0] OFF_SYSCLK = 28'h000_0108;

  // CTRL register bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_PEND = 2;

  // Decoded target of the current bus access
  typedef enum logic [2:0] {
    REG_RAM     = 3'd0,
    REG_TIMER   = 3'd1,
    REG_LEDS    = 3'd2,
    REG_DIGITS  = 3'd3,
    REG_SYSCLK  = 3'd4,
    REG_ILLEGAL = 3'd5
  } region_t;

  // Replace only the bytes whose enable is set
  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] new_word,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_peri_bus_timer.sv
// One reload timer channel: RELOAD/COUNT/CTRL registers, registered tick
// pulse on each wrap-to-reload and a level interrupt from IE & PEND.
module periph_timer
  import mem_peri_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_reload,
  input  logic        wr_count,
  input  logic        wr_ctrl,
  input  logic [31:0] wr_data,
  output logic [31:0] reload,
  output logic [31:0] count,
  output logic [2:0]  ctrl,
  output logic        tick,
  output logic        irq_o
);

  logic [31:0] reload_r, count_r;
  logic        en_r, ie_r, pend_r, tick_r;

  logic [31:0] reload_s, count_s;
  logic        en_s, ie_s, pend_s, tick_s, pend_set_s;

  // Next-state: CPU COUNT write beats a wrap, wrap beats increment; PEND set beats W1C
  always_comb begin
    count_s    = count_r;
    tick_s     = 1'b0;
    pend_set_s = 1'b0;
    if (wr_count) begin
      count_s = wr_data;
    end else if (en_r && (count_r == 32'hFFFF_FFFF)) begin
      count_s    = reload_r;
      tick_s     = 1'b1;
      pend_set_s = ie_r;
    end else if (en_r) begin
      count_s = count_r + 32'd1;
    end else begin
      count_s = count_r;
    end

    if (pend_set_s) begin
      pend_s = 1'b1;
    end else if (wr_ctrl && wr_data[CTRL_PEND]) begin
      pend_s = 1'b0;
    end else begin
      pend_s = pend_r;
    end

    en_s     = wr_ctrl   ? wr_data[CTRL_EN] : en_r;
    ie_s     = wr_ctrl   ? wr_data[CTRL_IE] : ie_r;
    reload_s = wr_reload ? wr_data          : reload_r;
  end

  // Timer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload_r <= 32'h0;
      count_r  <= 32'h0;
      en_r     <= 1'b0;
      ie_r     <= 1'b0;
      pend_r   <= 1'b0;
      tick_r   <= 1'b0;
    end else begin
      reload_r <= reload_s;
      count_r  <= count_s;
      en_r     <= en_s;
      ie_r     <= ie_s;
      pend_r   <= pend_s;
      tick_r   <= tick_s;
    end
  end

  assign reload = reload_r;
  assign count  = count_r;
  assign ctrl   = {pend_r, ie_r, en_r};
  assign tick   = tick_r;
  assign irq_o  = ie_r & pend_r;

endmodule

// File: rtl/mem_peri_bus.sv
// Data-side bus target on the MEM stage: byte-writable word RAM plus a
// peripheral page with reload timers, LED/digit registers and a cycle
// counter mirror. Reads return one cycle later; illegal accesses pulse bus_err.
module mem_peri_bus
  import mem_peri_pkg::*;
#(
  parameter int RAM_DEPTH  = 512,
  parameter int NUM_TIMERS = 2,
  parameter int LED_W      = 8,
  parameter int DIGIT_W    = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           clk_count,
  input  logic [31:0]           addr,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            be,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [31:0]           rd_data,
  output logic [LED_W-1:0]      leds,
  output logic [DIGIT_W-1:0]    digits,
  output logic [NUM_TIMERS-1:0] timer_tick,
  output logic                  irq,
  output logic                  bus_err
);

  localparam int         AW  = $clog2(RAM_DEPTH);
  localparam logic [4:0] NT5 = 5'(NUM_TIMERS);

  logic [31:0]        ram_r [RAM_DEPTH];
  logic [AW-1:0]      ram_idx_s;
  region_t            region_s;
  logic               peri_wr_s, ram_wr_s, err_s;
  logic [31:0]        rdata_s, t_rd_s;
  logic [31:0]        rd_data_r;
  logic               bus_err_r;
  logic [LED_W-1:0]   leds_r;
  logic [DIGIT_W-1:0] digits_r;

  logic [NUM_TIMERS-1:0] wr_reload_s, wr_count_s, wr_ctrl_s, tick_s, irq_vec_s;
  logic [31:0]           tword_s [NUM_TIMERS];

  assign ram_idx_s = addr[AW+1:2];

  // Address decode; peripheral registers must be word aligned
  always_comb begin
    region_s = REG_ILLEGAL;
    case (addr[31:28])
      RAM_NIBBLE:  region_s = REG_RAM;
      PERI_NIBBLE: begin
        if (addr[1:0] != 2'b00) begin
          region_s = REG_ILLEGAL;
        end else if ((addr[27:8] == 20'h0) && ({1'b0, addr[7:4]} < NT5) &&
                     (addr[3:2] != 2'b11)) begin
          region_s = REG_TIMER;
        end else if (addr[27:0] == OFF_LEDS) begin
          region_s = REG_LEDS;
        end else if (addr[27:0] == OFF_DIGITS) begin
          region_s = REG_DIGITS;
        end else if (addr[27:0] == OFF_SYSCLK) begin
          region_s = REG_SYSCLK;
        end else begin
          region_s = REG_ILLEGAL;
        end
      end
      default: region_s = REG_ILLEGAL;
    endcase
  end

  // Peripheral writes need all four byte lanes; RAM takes any byte mix
  assign peri_wr_s = mem_write && (be == 4'hF) &&
                     ((region_s == REG_TIMER) || (region_s == REG_LEDS) ||
                      (region_s == REG_DIGITS));
  assign ram_wr_s  = mem_write && (region_s == REG_RAM) && !reset;
  assign err_s     = (mem_read && (region_s == REG_ILLEGAL)) ||
                     (mem_write && ((region_s == REG_ILLEGAL) ||
                                    (region_s == REG_SYSCLK)  ||
                                    ((region_s != REG_RAM) && (be != 4'hF))));

  for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_timer
    logic hit_s;
    assign hit_s          = peri_wr_s && (region_s == REG_TIMER) && (addr[7:4] == 4'(k));
    assign wr_reload_s[k] = hit_s && (addr[3:2] == OFF_RELOAD);
    assign wr_count_s[k]  = hit_s && (addr[3:2] == OFF_COUNT);
    assign wr_ctrl_s[k]   = hit_s && (addr[3:2] == OFF_CTRL);

    logic [31:0] reload_v, count_v;
    logic [2:0]  ctrl_v;

    periph_timer u_timer (
      .clk       (clk),
      .reset     (reset),
      .wr_reload (wr_reload_s[k]),
      .wr_count  (wr_count_s[k]),
      .wr_ctrl   (wr_ctrl_s[k]),
      .wr_data   (wr_data),
      .reload    (reload_v),
      .count     (count_v),
      .ctrl      (ctrl_v),
      .tick      (tick_s[k]),
      .irq_o     (irq_vec_s[k])
    );

    // Register word of this channel selected by the in-slot offset
    always_comb begin
      case (addr[3:2])
        OFF_RELOAD: tword_s[k] = reload_v;
        OFF_COUNT:  tword_s[k] = count_v;
        OFF_CTRL:   tword_s[k] = {29'h0, ctrl_v};
        default:    tword_s[k] = 32'h0;
      endcase
    end
  end

  // Pick the addressed channel's word
  always_comb begin
    t_rd_s = 32'h0;
    for (int k = 0; k < NUM_TIMERS; k++) begin
      t_rd_s = t_rd_s | ((addr[7:4] == 4'(k)) ? tword_s[k] : 32'h0);
    end
  end

  // Read mux; values are the pre-write contents of this cycle
  always_comb begin
    case (region_s)
      REG_RAM:    rdata_s = ram_r[ram_idx_s];
      REG_TIMER:  rdata_s = t_rd_s;
      REG_LEDS:   rdata_s = 32'(leds_r);
      REG_DIGITS: rdata_s = 32'(digits_r);
      REG_SYSCLK: rdata_s = clk_count;
      default:    rdata_s = 32'h0;
    endcase
  end

  // RAM array without reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (ram_wr_s) begin
      ram_r[ram_idx_s] <= be_merge(ram_r[ram_idx_s], wr_data, be);
    end
  end

  // Registered read data, error pulse and display registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_r <= 32'h0;
      bus_err_r <= 1'b0;
      leds_r    <= '0;
      digits_r  <= '0;
    end else begin
      rd_data_r <= mem_read ? rdata_s : 32'h0;
      bus_err_r <= err_s;
      if (peri_wr_s && (region_s == REG_LEDS)) begin
        leds_r <= wr_data[LED_W-1:0];
      end
      if (peri_wr_s && (region_s == REG_DIGITS)) begin
        digits_r <= wr_data[DIGIT_W-1:0];
      end
    end
  end

  assign rd_data    = rd_data_r;
  assign bus_err    = bus_err_r;
  assign leds       = leds_r;
  assign digits     = digits_r;
  assign timer_tick = tick_s;
  assign irq        = |irq_vec_s;

endmodule

// File: tb/tb_mem_peri_bus.sv
// Self-checking bench for mem_peri_bus: a cycle-level reference model of the
// address map and timers plus directed sequences with literal expectations.
module tb_mem_peri_bus;

  localparam int NT        = 2;
  localparam int RAM_WORDS = 512;

  localparam logic [31:0] T0      = 32'h4000_0000;
  localparam logic [31:0] T1      = 32'h4000_0010;
  localparam logic [31:0] A_LEDS  = 32'h4000_0100;
  localparam logic [31:0] A_DIG   = 32'h4000_0104;
  localparam logic [31:0] A_SYS   = 32'h4000_0108;

  logic          clk, reset;
  logic [31:0]   clk_count, addr, wr_data;
  logic [3:0]    be;
  logic          mem_read, mem_write;
  logic [31:0]   rd_data;
  logic [7:0]    leds;
  logic [11:0]   digits;
  logic [NT-1:0] timer_tick;
  logic          irq, bus_err;

  int total = 0;
  int bad   = 0;

  mem_peri_bus #(.RAM_DEPTH(RAM_WORDS), .NUM_TIMERS(NT), .LED_W(8), .DIGIT_W(12)) dut (
    .clk(clk), .reset(reset), .clk_count(clk_count), .addr(addr), .wr_data(wr_data),
    .be(be), .mem_read(mem_read), .mem_write(mem_write), .rd_data(rd_data),
    .leds(leds), .digits(digits), .timer_tick(timer_tick), .irq(irq), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0]   m_reload [NT];
  logic [31:0]   m_count  [NT];
  bit            m_en [NT], m_ie [NT], m_pend [NT];
  logic [7:0]    m_leds   = 8'h0;
  logic [11:0]   m_digits = 12'h0;
  logic [31:0]   m_ram   [RAM_WORDS];
  bit            m_known [RAM_WORDS];
  logic [31:0]   e_rd = 32'h0;
  bit            e_rd_known = 1'b1;
  bit            e_err = 1'b0;
  logic [NT-1:0] e_tick = '0;

  // 0 RAM, 1 timer register, 2 LEDS, 3 DIGITS, 4 SYSCLK, 5 illegal
  function automatic int kind(input logic [31:0] a);
    int off;
    off = int'(a[27:0]);
    if (a[31:28] == 4'h0) return 0;
    if (a[31:28] != 4'h4) return 5;
    if (off % 4 != 0) return 5;
    if (off < 16 * NT && (off % 16) < 12) return 1;
    if (off == 256) return 2;
    if (off == 260) return 3;
    if (off == 264) return 4;
    return 5;
  endfunction

  function automatic bit m_irq();
    bit x = 1'b0;
    for (int t = 0; t < NT; t++) x = x | (m_ie[t] & m_pend[t]);
    return x;
  endfunction

  task automatic model_step();
    int k, ti, rg, idx;
    logic [31:0] rv;
    bit kn, wok, wc, wl, wct, tk;
    k   = kind(addr);
    ti  = int'(addr[27:0]) / 16;
    rg  = (int'(addr[27:0]) % 16) / 4;
    idx = int'(addr[10:2]);
    rv  = 32'h0;
    kn  = 1'b1;
    case (k)
      0: begin rv = m_ram[idx]; kn = m_known[idx]; end
      1: begin
        if (rg == 0)      rv = m_reload[ti];
        else if (rg == 1) rv = m_count[ti];
        else              rv = {29'h0, m_pend[ti], m_ie[ti], m_en[ti]};
      end
      2: rv = {24'h0, m_leds};
      3: rv = {20'h0, m_digits};
      4: rv = clk_count;
      default: rv = 32'h0;
    endcase
    e_rd       = mem_read ? rv : 32'h0;
    e_rd_known = mem_read ? kn : 1'b1;
    wok   = mem_write && (k == 0 || ((k >= 1 && k <= 3) && be == 4'hF));
    e_err = (mem_read && k == 5) || (mem_write && (k >= 4 || (k != 0 && be != 4'hF)));
    for (int t = 0; t < NT; t++) begin
      wl  = wok && k == 1 && ti == t && rg == 0;
      wc  = wok && k == 1 && ti == t && rg == 1;
      wct = wok && k == 1 && ti == t && rg == 2;
      tk  = 1'b0;
      if (wc) m_count[t] = wr_data;
      else if (m_en[t] && m_count[t] == 32'hFFFF_FFFF) begin
        m_count[t] = m_reload[t];
        tk = 1'b1;
      end else if (m_en[t]) m_count[t] = m_count[t] + 32'd1;
      e_tick[t] = tk;
      if (tk && m_ie[t]) m_pend[t] = 1'b1;
      else if (wct && wr_data[2]) m_pend[t] = 1'b0;
      if (wct) begin m_en[t] = wr_data[0]; m_ie[t] = wr_data[1]; end
      if (wl) m_reload[t] = wr_data;
    end
    if (wok && k == 0) begin
      for (int b = 0; b < 4; b++) if (be[b]) m_ram[idx][8*b +: 8] = wr_data[8*b +: 8];
      if (be == 4'hF) m_known[idx] = 1'b1;
    end
    if (wok && k == 2) m_leds = wr_data[7:0];
    if (wok && k == 3) m_digits = wr_data[11:0];
  endtask

  // Advance the model on each edge; reset clears it immediately
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < NT; t++) begin
        m_reload[t] = 32'h0; m_count[t] = 32'h0;
        m_en[t] = 1'b0; m_ie[t] = 1'b0; m_pend[t] = 1'b0;
      end
      for (int i = 0; i < RAM_WORDS; i++) m_known[i] = 1'b0;
      m_leds = 8'h0; m_digits = 12'h0;
      e_rd = 32'h0; e_rd_known = 1'b1; e_err = 1'b0; e_tick = '0;
    end else begin
      model_step();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare every output against the model mid-cycle
  always @(negedge clk) begin
    if (e_rd_known) chk("rd_data", rd_data, e_rd);
    chk("bus_err", 32'(bus_err), 32'(e_err));
    chk("timer_tick", 32'(timer_tick), 32'(e_tick));
    chk("irq", 32'(irq), 32'(m_irq()));
    chk("leds", 32'(leds), 32'(m_leds));
    chk("digits", 32'(digits), 32'(m_digits));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; wr_data = d; be = b; mem_write = 1'b1; mem_read = 1'b0;
    cyc();
    mem_write = 1'b0; be = 4'hF;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] v);
    addr = a; mem_read = 1'b1; mem_write = 1'b0;
    cyc();
    v = rd_data;
    mem_read = 1'b0;
  endtask

  logic [31:0] v;

  initial begin
    reset = 1'b1; clk_count = 32'h0; addr = 32'h0; wr_data = 32'h0;
    be = 4'hF; mem_read = 1'b0; mem_write = 1'b0;
    #12;
    chk("reset rd_data", rd_data, 32'h0);
    chk("reset leds", 32'(leds), 32'h0);
    chk("reset tick/irq/err", {29'h0, timer_tick, irq}, 32'h0);
    cyc();
    reset = 1'b0;
    cyc();

    // 1: byte-enable RAM writes, index wrap, read-first
    bus_wr(32'h10, 32'hAABB_CCDD, 4'hF);
    bus_wr(32'h10, 32'h1122_3344, 4'b0010);
    bus_rd(32'h10, v);  chk("ram be merge", v, 32'hAABB_33DD);
    bus_rd(32'h810, v); chk("ram wrap", v, 32'hAABB_33DD);
    addr = 32'h10; wr_data = 32'h55; be = 4'hF; mem_read = 1'b1; mem_write = 1'b1;
    cyc();
    mem_read = 1'b0; mem_write = 1'b0;
    chk("read-first", rd_data, 32'hAABB_33DD);
    bus_rd(32'h10, v);  chk("ram after rw", v, 32'h55);

    // 2: timer 0 wrap, reload, PEND and W1C
    bus_wr(T0 + 32'h0, 32'hFFFF_FFFC, 4'hF);
    bus_wr(T0 + 32'h4, 32'hFFFF_FFFE, 4'hF);
    bus_wr(T0 + 32'h8, 32'h3, 4'hF);
    cyc(); chk("t0 no tick yet", 32'(timer_tick), 32'h0);
    cyc(); chk("t0 tick", 32'(timer_tick), 32'h1);
    chk("t0 irq", 32'(irq), 32'h1);
    bus_rd(T0 + 32'h4, v); chk("t0 count reloaded", v, 32'hFFFF_FFFC);
    bus_rd(T0 + 32'h8, v); chk("t0 ctrl pend", v, 32'h7);
    bus_wr(T0 + 32'h8, 32'h7, 4'hF);
    chk("t0 irq cleared", 32'(irq), 32'h0);
    bus_wr(T0 + 32'h8, 32'h0, 4'hF);

    // 3: timer 1 set-beats-clear, and COUNT write beats wrap
    bus_wr(T1 + 32'h0, 32'h100, 4'hF);
    bus_wr(T1 + 32'h4, 32'hFFFF_FFFF, 4'hF);
    bus_wr(T1 + 32'h8, 32'h3, 4'hF);
    bus_wr(T1 + 32'h8, 32'h7, 4'hF);
    chk("t1 tick on clear", 32'(timer_tick), 32'h2);
    chk("t1 irq set wins", 32'(irq), 32'h1);
    bus_rd(T1 + 32'h8, v); chk("t1 ctrl set wins", v, 32'h7);
    bus_wr(T1 + 32'h8, 32'h7, 4'hF);
    bus_rd(T1 + 32'h8, v); chk("t1 ctrl cleared", v, 32'h3);
    bus_wr(T1 + 32'h4, 32'hFFFF_FFFF, 4'hF);
    bus_wr(T1 + 32'h4, 32'h1234, 4'hF);
    chk("t1 no tick on write", 32'(timer_tick), 32'h0);
    bus_rd(T1 + 32'h4, v); chk("t1 count written", v, 32'h1234);
    bus_rd(T1 + 32'h8, v); chk("t1 no pend", v, 32'h3);
    bus_wr(T1 + 32'h8, 32'h0, 4'hF);

    // 4: partial peripheral write and unmapped read
    bus_wr(A_DIG, 32'h123, 4'hF);
    bus_wr(A_DIG, 32'hFFF, 4'h3);
    chk("partial wr err", 32'(bus_err), 32'h1);
    chk("digits kept", 32'(digits), 32'h123);
    bus_rd(32'h8000_0000, v);
    chk("illegal rd data", v, 32'h0);
    chk("illegal rd err", 32'(bus_err), 32'h1);
    bus_wr(A_SYS, 32'h1, 4'hF);
    chk("sysclk wr err", 32'(bus_err), 32'h1);
    cyc();

    // 5: SYSCLK mirror and idle read data
    clk_count = 32'hCAFE_0042;
    bus_rd(A_SYS, v); chk("sysclk", v, 32'hCAFE_0042);
    cyc(); chk("idle rd_data", rd_data, 32'h0);

    // 6: asynchronous reset while counting
    bus_wr(A_LEDS, 32'h5A, 4'hF);
    chk("leds set", 32'(leds), 32'h5A);
    bus_wr(T0 + 32'h4, 32'h0, 4'hF);
    bus_wr(T0 + 32'h8, 32'h1, 4'hF);
    repeat (3) cyc();
    #1 reset = 1'b1;
    #1;
    chk("async rst leds", 32'(leds), 32'h0);
    chk("async rst outs", {rd_data[28:0], timer_tick, irq}, 32'h0);
    cyc(); cyc();
    reset = 1'b0;
    bus_rd(T0 + 32'h4, v); chk("count held after rst", v, 32'h0);
    repeat (3) cyc();
    bus_rd(T0 + 32'h4, v); chk("count still held", v, 32'h0);
    bus_wr(T0 + 32'h8, 32'h1, 4'hF);
    cyc(); cyc();
    bus_rd(T0 + 32'h4, v); chk("count resumes", v, 32'h2);
    repeat (3) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
